filtered_trace_streamer: RTL and testbench
==========================================

FILTERED_TRACE_STREAMER -- requirements
Module: filtered_trace_streamer

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning program-counter width.
REQ-002 The block SHALL have parameter AXI_DATA_WIDTH, default XLEN+32, meaning stream beat width; values below XLEN+32 are illegal.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, meaning buffered beats; power of two, at least 2.
REQ-004 Ports SHALL be:
  clk  in  1  sole clock, all logic on rising edge
  rst_n  in  1  reset, synchronous and active-low
  instr  in  32  retired instruction word
  pc  in  XLEN  retired instruction address
  pc_valid  in  1  instr/pc valid this cycle
  filter_mode  in  2  0=all, 1=control-flow only, 2=mask/match, 3=capture disabled
  match_mask  in  32  mode-2 mask
  match_value  in  32  mode-2 compare value
  tlast_interval  in  32  beats per packet
  flush  in  1  close current packet early
  M_AXIS_tvalid  out  1  beat valid
  M_AXIS_tready  in  1  downstream ready
  M_AXIS_tdata  out  AXI_DATA_WIDTH  beat payload
  M_AXIS_tlast  out  1  final beat of packet
  drop_count  out  32  samples lost to overflow, saturating
  fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held

Function
REQ-005 A sample SHALL be accepted when pc_valid=1 and the filter matches: mode 0 always; mode 1 when instr[6:0] is 1100011, 1101111 or 1100111; mode 2 when (instr & match_mask)==match_value; mode 3 never.
REQ-006 An accepted sample SHALL be written as tdata={zero pad, instr, pc}, pc in bits [XLEN-1:0], instr in bits [XLEN+31:XLEN].
REQ-007 Write-to-output latency SHALL be one cycle: a sample accepted in cycle N into an empty FIFO appears with M_AXIS_tvalid=1 in cycle N+1.
REQ-008 M_AXIS_tvalid SHALL equal (fifo_level!=0); a beat pops only when tvalid and tready are both 1; tdata/tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-009 A beat counter SHALL count accepted writes; the write making it reach max(tlast_interval,1) SHALL carry last=1 and clear the counter to 0.
REQ-010 flush coinciding with an accepted write SHALL give that entry last=1 and clear the counter.
REQ-011 flush without a write SHALL set last=1 on the newest stored entry and clear the counter; ignored if FIFO empty or the newest entry pops that cycle.
REQ-012 Full FIFO with no pop: an accepted sample SHALL be dropped, drop_count incremented (saturating at 32'hFFFFFFFF), beat counter unchanged.
REQ-013 Full FIFO with simultaneous pop: the accepted sample SHALL be written, no drop.
REQ-014 Simultaneous write and pop at any level SHALL leave fifo_level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-015 Changing filter_mode or tlast_interval SHALL take effect on the next cycle and never corrupt stored entries.

Reset
REQ-016 While rst_n=0 at a rising clk edge: pointers, fifo_level, beat counter, drop_count SHALL clear to 0; M_AXIS_tvalid=0, M_AXIS_tlast=0, M_AXIS_tdata=0.
REQ-017 Reset mid-packet SHALL discard all buffered beats; no sample is accepted in the reset cycle.

Structure
REQ-018 Shared package cms_pkg SHALL hold the filter-mode encoding and the RISC-V opcode constants BRANCH, JAL, JALR.
REQ-019 Storage SHALL be a sub-module cms_sync_fifo (parametrised width, depth, show-ahead output, level output) with the last bit as part of each entry.

Verification
REQ-020 Mode 0, tlast_interval=3, tready=1, 7 valid samples pc=8..32 step 4 -> 7 beats, tlast on beats 3 and 6, beat 1 tdata[63:0]=8.
REQ-021 Mode 1, stream nop, 0x0000006f, 0x00c5c063, 0x00000067, addi -> exactly 3 beats with instr 0x6f, 0x00c5c063, 0x67.
REQ-022 FIFO_DEPTH=4, tready=0, 6 accepted samples -> fifo_level=4, drop_count=2, tvalid held with first sample's tdata.
REQ-023 Full FIFO, tready=1 and accepted sample same cycle -> fifo_level stays 4, drop_count unchanged.
REQ-024 tlast_interval=8, 2 samples then flush idle cycle -> beat 2 tlast=1; next 8 samples tlast only on 8th.
REQ-025 rst_n=0 for one cycle with 3 beats buffered -> next cycle tvalid=0, fifo_level=0, drop_count=0.

Source files
------------

// File: rtl/cms_pkg.sv
// ============================================================================
// Module  : cms_pkg
// Brief   : Shared filter-mode encoding and RISC-V opcode constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package cms_pkg;

  typedef enum logic [1:0] {
    FILT_ALL  = 2'd0,
    FILT_CTRL = 2'd1,
    FILT_MASK = 2'd2,
    FILT_OFF  = 2'd3
  } filter_mode_e;

  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  function automatic logic is_ctrl_flow(input logic [31:0] instr);
    return (instr[6:0] == BRANCH) || (instr[6:0] == JAL) || (instr[6:0] == JALR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cms_sync_fifo.sv
// ============================================================================
// Module  : cms_sync_fifo
// Brief   : Show-ahead synchronous FIFO with level output and a "mark newest
//           entry" strobe that sets the top bit of the most recent write
// Revision: 1.0
// ============================================================================
`default_nettype none

module cms_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic                     mark_last,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_level;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_do_rd = rd_en && (r_level != '0);
  // A write into a full FIFO is only legal when a read frees a slot that cycle.
  assign w_do_wr = wr_en && ((r_level != c_FULL) || w_do_rd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_wr && !w_do_rd)      r_level <= r_level + 1'b1;
      else if (w_do_rd && !w_do_wr) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr)   r_mem[r_wr_ptr] <= wr_data;
    if (mark_last) r_mem[r_wr_ptr - 1'b1][WIDTH-1] <= 1'b1;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign level   = r_level;

endmodule

`default_nettype wire

// File: rtl/filtered_trace_streamer.sv
// ============================================================================
// Module  : filtered_trace_streamer
// Brief   : Filters retired-instruction samples and streams them as AXI4-Stream
//           beats with packetisation, flush and saturating drop counting
// Revision: 1.0
// ============================================================================
`default_nettype none

module filtered_trace_streamer
  import cms_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int AXI_DATA_WIDTH = XLEN + 32,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   instr,
  input  logic [XLEN-1:0]               pc,
  input  logic                          pc_valid,
  input  logic [1:0]                    filter_mode,
  input  logic [31:0]                   match_mask,
  input  logic [31:0]                   match_value,
  input  logic [31:0]                   tlast_interval,
  input  logic                          flush,
  output logic                          M_AXIS_tvalid,
  input  logic                          M_AXIS_tready,
  output logic [AXI_DATA_WIDTH-1:0]     M_AXIS_tdata,
  output logic                          M_AXIS_tlast,
  output logic [31:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int c_LW      = $clog2(FIFO_DEPTH) + 1;
  localparam int c_ENTRY_W = AXI_DATA_WIDTH + 1;
  localparam logic [c_LW-1:0] c_FULL = c_LW'(FIFO_DEPTH);

  logic                      w_match;
  logic                      w_accept;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_write;
  logic                      w_drop;
  logic                      w_mark;
  logic                      w_last;
  logic [31:0]               w_limit;
  logic [31:0]               w_cnt_next;
  logic [AXI_DATA_WIDTH-1:0] w_payload;
  logic [c_ENTRY_W-1:0]      w_rd_entry;
  logic [c_LW-1:0]           w_level;
  logic [31:0]               r_beat_cnt;
  logic [31:0]               r_drop_cnt;

  always_comb begin
    w_match = 1'b0;
    unique case (filter_mode_e'(filter_mode))
      FILT_ALL:  w_match = 1'b1;
      FILT_CTRL: w_match = is_ctrl_flow(instr);
      FILT_MASK: w_match = ((instr & match_mask) == match_value);
      FILT_OFF:  w_match = 1'b0;
      default:   w_match = 1'b0;
    endcase
  end

  assign w_accept   = pc_valid && w_match;
  assign w_pop      = M_AXIS_tvalid && M_AXIS_tready;
  assign w_full     = (w_level == c_FULL);
  assign w_write    = w_accept && (!w_full || w_pop);
  assign w_drop     = w_accept && w_full && !w_pop;
  assign w_limit    = (tlast_interval == 32'd0) ? 32'd1 : tlast_interval;
  assign w_cnt_next = r_beat_cnt + 32'd1;
  // >= rather than == so a shrunk interval closes the packet immediately.
  assign w_last     = flush || (w_cnt_next >= w_limit);
  assign w_mark     = flush && !w_write && (w_level != '0)
                      && !(w_pop && (w_level == c_LW'(1)));

  generate
    if (AXI_DATA_WIDTH > XLEN + 32) begin : g_pad
      assign w_payload = {{(AXI_DATA_WIDTH - XLEN - 32){1'b0}}, instr, pc};
    end else begin : g_nopad
      assign w_payload = {instr, pc};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_write)     r_beat_cnt <= w_last ? 32'd0 : w_cnt_next;
      else if (w_mark) r_beat_cnt <= 32'd0;
      if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF)) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  cms_sync_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (w_write),
    .wr_data   ({w_last, w_payload}),
    .rd_en     (w_pop),
    .mark_last (w_mark),
    .rd_data   (w_rd_entry),
    .level     (w_level)
  );

  // Storage is not reset, so the output is forced to zero whenever empty.
  assign M_AXIS_tvalid = (w_level != '0);
  assign M_AXIS_tdata  = M_AXIS_tvalid ? w_rd_entry[AXI_DATA_WIDTH-1:0] : '0;
  assign M_AXIS_tlast  = M_AXIS_tvalid && w_rd_entry[c_ENTRY_W-1];
  assign drop_count    = r_drop_cnt;
  assign fifo_level    = w_level;

endmodule

`default_nettype wire

// File: tb/tb_filtered_trace_streamer.sv
// ============================================================================
// Module  : tb_filtered_trace_streamer
// Brief   : Directed-vector scoreboard bench for filtered_trace_streamer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_filtered_trace_streamer;

  localparam int XLEN  = 64;
  localparam int DW    = XLEN + 32;
  localparam int DEPTH = 4;

  typedef logic [DW:0] ent_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     instr = '0;
  logic [XLEN-1:0] pc = '0;
  logic            pc_valid = 1'b0;
  logic [1:0]      filter_mode = 2'd0;
  logic [31:0]     match_mask = '0;
  logic [31:0]     match_value = '0;
  logic [31:0]     tlast_interval = 32'd0;
  logic            flush = 1'b0;
  logic            M_AXIS_tvalid;
  logic            M_AXIS_tready = 1'b0;
  logic [DW-1:0]   M_AXIS_tdata;
  logic            M_AXIS_tlast;
  logic [31:0]     drop_count;
  logic [2:0]      fifo_level;

  ent_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  filtered_trace_streamer #(
    .XLEN           (XLEN),
    .AXI_DATA_WIDTH (DW),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr          (instr),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .filter_mode    (filter_mode),
    .match_mask     (match_mask),
    .match_value    (match_value),
    .tlast_interval (tlast_interval),
    .flush          (flush),
    .M_AXIS_tvalid  (M_AXIS_tvalid),
    .M_AXIS_tready  (M_AXIS_tready),
    .M_AXIS_tdata   (M_AXIS_tdata),
    .M_AXIS_tlast   (M_AXIS_tlast),
    .drop_count     (drop_count),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  // Monitor: every handshake beat is popped from the scoreboard and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (M_AXIS_tvalid && M_AXIS_tready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat: unexpected beat tlast=%0b tdata=%0h, none expected",
                   M_AXIS_tlast, M_AXIS_tdata);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          if ({M_AXIS_tlast, M_AXIS_tdata} !== e) begin
            n_err++;
            $display("FAIL beat: got tlast=%0b tdata=%0h, expected tlast=%0b tdata=%0h",
                     M_AXIS_tlast, M_AXIS_tdata, e[DW], e[DW-1:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] i, input logic [63:0] p,
                      input bit acc, input bit lst, input bit fl);
    instr    = i;
    pc       = p;
    pc_valid = 1'b1;
    flush    = fl;
    if (acc) exp_q.push_back({lst, i, p});
    tick();
    pc_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
    tick();
    chk({name, "_pending"}, 128'(exp_q.size()), 128'd0);
    chk({name, "_level"}, 128'(fifo_level), 128'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_tvalid", 128'(M_AXIS_tvalid), 128'd0);
    chk("rst_level", 128'(fifo_level), 128'd0);
    chk("rst_drop", 128'(drop_count), 128'd0);
    chk("rst_tdata", 128'(M_AXIS_tdata), 128'd0);
    chk("rst_tlast", 128'(M_AXIS_tlast), 128'd0);
    rst_n = 1'b1;

    // Mode 0, packets of 3, pc 8..32
    filter_mode    = 2'd0;
    tlast_interval = 32'd3;
    M_AXIS_tready  = 1'b1;
    for (int i = 0; i < 7; i++)
      send(32'h0000_0013, 64'(8 + 4 * i), 1'b1, (i == 2) || (i == 5), 1'b0);
    wait_drain("mode0");

    // Mode 1 (control flow), interval 0 behaves as 1: every beat is last
    do_reset();
    filter_mode    = 2'd1;
    tlast_interval = 32'd0;
    send(32'h0000_0013, 64'h100, 1'b0, 1'b0, 1'b0);
    send(32'h0000_006f, 64'h104, 1'b1, 1'b1, 1'b0);
    send(32'h00c5_c063, 64'h108, 1'b1, 1'b1, 1'b0);
    send(32'h0000_0067, 64'h10c, 1'b1, 1'b1, 1'b0);
    send(32'h0010_0093, 64'h110, 1'b0, 1'b0, 1'b0);
    // Mode 2 mask/match on R-type opcode, then mode 3 drops everything
    filter_mode = 2'd2;
    match_mask  = 32'h0000_007f;
    match_value = 32'h0000_0033;
    send(32'h00b5_0533, 64'h200, 1'b1, 1'b1, 1'b0);
    send(32'h00a0_0513, 64'h204, 1'b0, 1'b0, 1'b0);
    filter_mode = 2'd3;
    send(32'h0000_006f, 64'h208, 1'b0, 1'b0, 1'b0);
    wait_drain("modes");

    // Flush on idle cycle, then a full packet of 8, then flush with write
    do_reset();
    filter_mode    = 2'd0;
    tlast_interval = 32'd8;
    M_AXIS_tready  = 1'b0;
    send(32'h0000_0013, 64'h300, 1'b1, 1'b0, 1'b0);
    send(32'h0000_0013, 64'h304, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    M_AXIS_tready = 1'b1;
    for (int i = 0; i < 8; i++)
      send(32'h0000_0013, 64'(32'h400 + 4 * i), 1'b1, i == 7, 1'b0);
    send(32'h0000_0013, 64'h500, 1'b1, 1'b1, 1'b1);
    wait_drain("flush");

    // Overflow with depth 4 and a stalled sink
    do_reset();
    tlast_interval = 32'd100;
    M_AXIS_tready  = 1'b0;
    for (int i = 0; i < 6; i++)
      send(32'h0000_0013, 64'(32'h600 + 4 * i), i < 4, 1'b0, 1'b0);
    tick();
    tick();
    chk("ovf_level", 128'(fifo_level), 128'd4);
    chk("ovf_drop", 128'(drop_count), 128'd2);
    chk("ovf_tvalid", 128'(M_AXIS_tvalid), 128'd1);
    chk("ovf_hold_tdata", 128'(M_AXIS_tdata), {32'h0, 32'h0000_0013, 64'h600});
    tick();
    chk("ovf_hold_tdata2", 128'(M_AXIS_tdata), {32'h0, 32'h0000_0013, 64'h600});

    // Full FIFO with simultaneous pop and write: no drop, level stays
    M_AXIS_tready = 1'b1;
    send(32'h0000_0013, 64'h700, 1'b1, 1'b0, 1'b0);
    M_AXIS_tready = 1'b0;
    chk("full_pop_level", 128'(fifo_level), 128'd4);
    chk("full_pop_drop", 128'(drop_count), 128'd2);
    M_AXIS_tready = 1'b1;
    wait_drain("full_pop");

    // Reset with beats buffered discards them, sample in reset cycle ignored
    M_AXIS_tready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(32'h0000_0013, 64'(32'h800 + 4 * i), 1'b1, 1'b0, 1'b0);
    chk("prerst_level", 128'(fifo_level), 128'd3);
    rst_n    = 1'b0;
    pc_valid = 1'b1;
    tick();
    rst_n    = 1'b1;
    pc_valid = 1'b0;
    exp_q.delete();
    chk("midrst_tvalid", 128'(M_AXIS_tvalid), 128'd0);
    chk("midrst_level", 128'(fifo_level), 128'd0);
    chk("midrst_drop", 128'(drop_count), 128'd0);
    tick();
    chk("midrst_level2", 128'(fifo_level), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
